controle_votacao: RTL and testbench

- Sequences the day-phase vote. Polls each living player in turn, latches their chosen target from the player buttons, and tallies votes per target.
- Picks the player to eliminate, or reports a tie or no-elimination.
- Sits between the main control unit and the datapath's elimination logic. The control unit pulses start and consumes the done pulse and result.

---
 rtl/controle_votacao.sv | 141 ++++++++++++++
 tb/tb_controle_votacao.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_votacao.sv
// controle_votacao: day-phase vote sequencer; polls each living player, tallies
// their votes and reports the player to eliminate, a tie, or no elimination.
module controle_votacao #(
    parameter int N_JOGADORES    = 5,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iniciar,
    input  logic [N_JOGADORES-1:0] vivos,
    input  logic [N_JOGADORES-1:0] botoes,
    input  logic                   confirma,
    output logic                   ocupado,
    output logic [2:0]             jogador_votante,
    output logic [2:0]             escolha_atual,
    output logic                   pronto,
    output logic [2:0]             eliminado,
    output logic                   empate,
    output logic [3:0]             db_estado
);
    localparam int TW = $clog2(TIMEOUT_CICLOS);
    localparam logic [2:0] ULTIMO = 3'(N_JOGADORES - 1);
    localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        OCIOSO   = 4'd0,
        INICIA   = 4'd1,
        PROXIMO  = 4'd2,
        ESPERA   = 4'd3,
        REGISTRA = 4'd4,
        APURA    = 4'd5,
        FIM      = 4'd6
    } estado_t;

    estado_t estado, proximo;
    logic [N_JOGADORES-1:0] mascara;
    logic [2:0] indice, alvo, maximo, maximo_n, vencedor, vencedor_n;
    logic [2:0] votos [N_JOGADORES];
    logic [TW-1:0] espera;
    logic empatado, empatado_n, valido, maior, igual;

    always_comb begin
        alvo = 3'd7;
        for (int i = 0; i < N_JOGADORES; i++)
            if (botoes[i]) alvo = 3'(i);
    end

    assign valido = $onehot(botoes) && mascara[alvo] && alvo != indice;

    // one step of the argmax scan over the tallies, indexed by indice
    always_comb begin
        maior = votos[indice] > maximo;
        igual = votos[indice] == maximo && maximo != 3'd0;
        maximo_n = maior ? votos[indice] : maximo;
        vencedor_n = maior ? indice : vencedor;
        empatado_n = !maior && (igual || empatado);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else estado <= proximo;
    end

    // the last player is handled without an extra PROXIMO visit, so a round always
    // spends exactly N_JOGADORES cycles in PROXIMO
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:   proximo = iniciar ? INICIA : OCIOSO;
            INICIA:   proximo = PROXIMO;
            PROXIMO:  proximo = int'(indice) >= N_JOGADORES ? APURA :
                                mascara[indice] ? ESPERA :
                                indice == ULTIMO ? APURA : PROXIMO;
            ESPERA:   proximo = (confirma || espera == LIMITE) ? REGISTRA : ESPERA;
            REGISTRA: proximo = indice == ULTIMO ? APURA : PROXIMO;
            APURA:    proximo = indice == ULTIMO ? FIM : APURA;
            FIM:      proximo = OCIOSO;
            default:  proximo = OCIOSO;
        endcase
    end

    assign ocupado = estado != OCIOSO;
    assign pronto = estado == FIM;
    assign db_estado = estado;
    assign jogador_votante = (estado == ESPERA || estado == REGISTRA) ? indice : 3'd7;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mascara <= '0;
            indice <= '0;
            espera <= '0;
            escolha_atual <= 3'd7;
            eliminado <= 3'd7;
            empate <= 1'b0;
            maximo <= '0;
            vencedor <= '0;
            empatado <= 1'b0;
            for (int i = 0; i < N_JOGADORES; i++) votos[i] <= '0;
        end else begin
            case (estado)
                OCIOSO: if (iniciar) begin
                    mascara <= vivos;
                    indice <= '0;
                    maximo <= '0;
                    vencedor <= '0;
                    empatado <= 1'b0;
                    eliminado <= 3'd7;
                    empate <= 1'b0;
                    escolha_atual <= 3'd7;
                    for (int i = 0; i < N_JOGADORES; i++) votos[i] <= '0;
                end
                PROXIMO: begin
                    if (proximo == ESPERA) begin
                        escolha_atual <= 3'd7;
                        espera <= '0;
                    end else indice <= proximo == APURA ? 3'd0 : indice + 3'd1;
                end
                ESPERA: begin
                    if (valido) escolha_atual <= alvo;
                    espera <= espera + TW'(1);
                end
                REGISTRA: begin
                    if (escolha_atual != 3'd7 && votos[escolha_atual] != 3'd7)
                        votos[escolha_atual] <= votos[escolha_atual] + 3'd1;
                    indice <= proximo == APURA ? 3'd0 : indice + 3'd1;
                end
                APURA: begin
                    maximo <= maximo_n;
                    vencedor <= vencedor_n;
                    empatado <= empatado_n;
                    indice <= indice + 3'd1;
                    if (indice == ULTIMO) begin
                        eliminado <= (maximo_n == 3'd0 || empatado_n) ? 3'd7 : vencedor_n;
                        empate <= empatado_n;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_controle_votacao.sv
// tb_controle_votacao: directed vote rounds checked against a tally model of the
// voting rules, plus literal expectations for each scenario.
`timescale 1ns/1ps
module tb_controle_votacao;
    localparam int N = 5;
    localparam int T = 20;

    logic clock = 1'b0, reset = 1'b1, iniciar = 1'b0, confirma = 1'b0;
    logic [N-1:0] vivos = '0, botoes = '0;
    logic ocupado, pronto, empate;
    logic [2:0] jogador_votante, escolha_atual, eliminado;
    logic [3:0] db_estado;

    int compared = 0, mismatched = 0, cyc = 0, t_ini = 0, exp_lat = 0;
    logic [N-1:0] m_mask = '0;
    int m_votes [N];
    logic [2:0] exp_elim = 3'd7, hold_elim = 3'd7;
    logic exp_emp = 1'b0, hold_emp = 1'b0, exp_valid = 1'b0;

    controle_votacao #(.N_JOGADORES(N), .TIMEOUT_CICLOS(T)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .vivos(vivos),
        .botoes(botoes), .confirma(confirma), .ocupado(ocupado),
        .jogador_votante(jogador_votante), .escolha_atual(escolha_atual),
        .pronto(pronto), .eliminado(eliminado), .empate(empate), .db_estado(db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clock) begin
        if (reset) begin
            hold_elim = 3'd7;
            hold_emp = 1'b0;
        end else begin
            if (iniciar && !ocupado) t_ini = cyc;
            if (pronto) begin
                check("pronto_esperado", int'(exp_valid), 1);
                check("eliminado", eliminado, exp_elim);
                check("empate", empate, exp_emp);
                check("ocupado_no_pronto", ocupado, 1);
                if (exp_lat != 0) check("latencia", cyc - t_ini, exp_lat);
                hold_elim = exp_elim;
                hold_emp = exp_emp;
            end else if (!ocupado) begin
                check("eliminado_mantido", eliminado, hold_elim);
                check("empate_mantido", empate, hold_emp);
                check("votante_ocioso", jogador_votante, 7);
            end
            if (db_estado == 4'd3) check("votante_vivo", int'((m_mask >> jogador_votante) & 1'b1), 1);
        end
    end

    task automatic start(input logic [N-1:0] mask, input int lat);
        @(posedge clock);
        #1;
        vivos = mask;
        iniciar = 1'b1;
        m_mask = mask;
        exp_lat = lat;
        foreach (m_votes[i]) m_votes[i] = 0;
        @(posedge clock);
        #1 iniciar = 1'b0;
    endtask

    task automatic wait_espera(input int voter);
        int c = 0;
        @(negedge clock);
        while (db_estado != 4'd3 && c < 100) begin
            @(negedge clock);
            c++;
        end
        check("espera_alcancada", int'(db_estado == 4'd3), 1);
        check("votante", jogador_votante, voter);
    endtask

    task automatic press(input logic [N-1:0] b);
        botoes = b;
        @(posedge clock);
        #1 botoes = '0;
        @(negedge clock);
    endtask

    task automatic confirm_only();
        confirma = 1'b1;
        @(posedge clock);
        #1 confirma = 1'b0;
    endtask

    task automatic vote(input int voter, input int tgt);
        bit ok;
        wait_espera(voter);
        ok = m_mask[tgt] && tgt != voter;
        botoes = N'(1) << tgt;
        confirma = 1'b1;
        @(posedge clock);
        #1;
        botoes = '0;
        confirma = 1'b0;
        check("escolha_registrada", escolha_atual, ok ? tgt : 7);
        if (ok) m_votes[tgt]++;
    endtask

    task automatic abstain_timeout(input int voter);
        int c = 0;
        wait_espera(voter);
        while (db_estado == 4'd3 && c < 100) begin
            c++;
            @(negedge clock);
        end
        check("timeout_ciclos", c, T);
        check("timeout_abstencao", escolha_atual, 7);
    endtask

    task automatic finish_round();
        int mx = 0, cnt = 0, arg = 7, c = 0;
        for (int i = 0; i < N; i++) begin
            int v = m_votes[i] > 7 ? 7 : m_votes[i];
            if (v > mx) begin
                mx = v;
                arg = i;
            end
        end
        for (int i = 0; i < N; i++) if ((m_votes[i] > 7 ? 7 : m_votes[i]) == mx) cnt++;
        exp_elim = (mx == 0 || cnt > 1) ? 3'd7 : 3'(arg);
        exp_emp = mx != 0 && cnt > 1;
        exp_valid = 1'b1;
        @(negedge clock);
        while (!pronto && c < 200) begin
            @(negedge clock);
            c++;
        end
        check("pronto_visto", int'(pronto), 1);
        @(posedge clock);
        exp_valid = 1'b0;
        #1;
    endtask

    initial begin
        #12;
        check("rst_ocupado", ocupado, 0);
        check("rst_pronto", pronto, 0);
        check("rst_empate", empate, 0);
        check("rst_eliminado", eliminado, 7);
        check("rst_votante", jogador_votante, 7);
        check("rst_escolha", escolha_atual, 7);
        check("rst_estado", db_estado, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        start(5'b11111, 22);
        vote(0, 2); vote(1, 2); vote(2, 0); vote(3, 2); vote(4, 1);
        finish_round();
        check("t1_eliminado", eliminado, 2);
        check("t1_empate", empate, 0);

        start(5'b10110, 18);
        vote(1, 4); vote(2, 1); vote(4, 1);
        finish_round();
        check("t2_eliminado", eliminado, 1);

        start(5'b01111, 20);
        vote(0, 1); vote(1, 0); vote(2, 1); vote(3, 0);
        finish_round();
        check("t3_eliminado", eliminado, 7);
        check("t3_empate", empate, 1);

        start(5'b00000, 12);
        finish_round();
        check("vazio_eliminado", eliminado, 7);
        check("vazio_empate", empate, 0);

        start(5'b00011, 0);
        wait_espera(0);
        press(5'b00001);
        check("auto_voto", escolha_atual, 7);
        confirm_only();
        abstain_timeout(1);
        finish_round();
        check("t4_eliminado", eliminado, 7);
        check("t4_empate", empate, 0);

        start(5'b00111, 0);
        wait_espera(0);
        press(5'b00110);
        check("dois_botoes", escolha_atual, 7);
        press(5'b10000);
        check("alvo_morto", escolha_atual, 7);
        press(5'b00100);
        check("botao_valido", escolha_atual, 2);
        confirm_only();
        m_votes[2]++;
        vote(1, 2); vote(2, 0);
        finish_round();
        check("t5_eliminado", eliminado, 2);

        start(5'b00011, 0);
        wait_espera(0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("reset_ocupado", ocupado, 0);
        check("reset_votante", jogador_votante, 7);
        check("reset_estado", db_estado, 0);
        check("reset_escolha", escolha_atual, 7);
        @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;

        start(5'b00011, 0);
        wait_espera(0);
        iniciar = 1'b1;
        vivos = 5'b11111;
        @(posedge clock);
        #1 iniciar = 1'b0;
        @(negedge clock);
        check("iniciar_ignorado", db_estado, 3);
        vote(0, 1); vote(1, 4);
        finish_round();
        check("t6_eliminado", eliminado, 1);
        check("t6_empate", empate, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end
endmodule
